imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the core's 128-word instruction memory; the core is the memory's reader.
- Accepts a byte stream from a host link (valid/ready), assembles little-endian 32-bit instruction words and writes them to sequential word addresses.
- Holds the core in reset while loading and releases it once the programmed word count has been written.
- Sits between the host byte source and the instruction memory write port, and drives the core reset.

Parameters:
- ADDR_WIDTH, 7, instruction memory word-address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  one-cycle pulse; begins a load from IDLE or DONE
- in_valid  input  1  host byte valid
- in_data  input  8  host byte
- in_ready  output  1  loader accepts a byte when in_valid && in_ready at posedge clk
- mem_addr  output  ADDR_WIDTH  instruction memory write word address
- mem_data  output  32  instruction memory write data
- mem_wren  output  1  instruction memory write enable, one-cycle pulse per word
- core_reset  output  1  reset to the core; high unless the state is DONE
- busy  output  1  high in HDR0, HDR1, DATA and WRITE
- done  output  1  high in DONE
- overflow  output  1  sticky; set when the header count exceeds the memory depth
- words_loaded  output  16  count of words completed in the current load

Behaviour:
- Stream format: 2 header bytes N[7:0], then N[15:8]; then N×4 payload bytes, each word LSB first.
- Reset values:
  - State is IDLE.
  - in_ready=0, mem_wren=0, mem_addr=0, mem_data=0.
  - core_reset=1, busy=0, done=0, overflow=0, words_loaded=0.
- core_reset = reset OR (state != DONE). It is combinational from the state register.
- IDLE:
  - in_ready=0.
  - start → HDR0; clear words_loaded, overflow and the byte counter.
- HDR0:
  - in_ready=1.
  - On a handshake, latch N[7:0] → HDR1.
- HDR1:
  - in_ready=1.
  - On a handshake, latch N[15:8].
  - If the full N==0 → DONE directly. Otherwise → DATA.
  - If N > 2**ADDR_WIDTH, set overflow in the same cycle.
- DATA:
  - in_ready=1.
  - Each handshake shifts the byte into lane byte_cnt (0..3) of the word buffer; byte_cnt increments.
  - On the handshake with byte_cnt==3 → WRITE; byte_cnt wraps to 0.
- WRITE (exactly 1 cycle):
  - in_ready=0.
  - mem_data = assembled word; mem_addr = words_loaded[ADDR_WIDTH-1:0].
  - mem_wren=1 only if words_loaded < 2**ADDR_WIDTH. Words beyond the depth are consumed and discarded, with mem_wren=0.
  - words_loaded increments at the end of the cycle.
  - → DONE if the incremented count == N, else → DATA.
- DONE:
  - in_ready=0, done=1, core_reset=0.
  - start → HDR0 with the same clears as IDLE; core_reset reasserts on the next cycle.
- start is ignored in HDR0, HDR1, DATA and WRITE.
- in_valid with in_ready=0 is not consumed; the host must hold the byte.
- Throughput: 5 cycles per word minimum (4 byte handshakes + 1 WRITE). Back-pressure from in_valid low stalls in place with no timeout.
- Write latency: mem_wren is asserted the cycle after the 4th byte handshake.
- Reset mid-load returns to IDLE immediately. Words already written stay in memory (no rollback). overflow and words_loaded clear.
- mem_addr and mem_data are held at their last values outside WRITE; only mem_wren qualifies them.
- words_loaded wraps naturally at 16 bits; this cannot occur because N ≤ 65535.

Decomposition:
- Shared package (core_pkg):
  - loader_state_t enum: IDLE, HDR0, HDR1, DATA, WRITE, DONE.
  - IMEM_ADDR_WIDTH=7 and INSTR_WIDTH=32 constants, also used by the core and memory wrappers.
- One sub-module, word_assembler:
  - byte_cnt, the 4-lane shift/load buffer and the word_full strobe.
  - Inputs: clk, reset, clear, byte_en, byte_in.
  - Outputs: word[31:0], word_full.
- The FSM, header latch and address/count registers stay in imem_loader.

Test Plan:
- Reset then start; bytes 02 00 13 05 A0 00 B3 85 A5 00 with in_valid held high:
  - mem_wren pulses twice: addr 0 data 0x00A00513, then addr 1 data 0x00A585B3.
  - done=1 and core_reset=0 after the second WRITE; words_loaded=2.
- Header 00 00 → DONE the cycle after the HDR1 handshake; no mem_wren pulse; core_reset=0.
- Same 2-word stream with in_valid toggling every other cycle → identical writes and addresses; no byte lost or duplicated; in_ready=0 during each WRITE cycle.
- Header 81 00 (129 words) and 516 payload bytes:
  - overflow=1 after HDR1.
  - 128 mem_wren pulses at addresses 0..127; the 129th word gives no pulse.
  - done=1; words_loaded=129.
- Assert reset after 6 payload bytes of a 2-word load → IDLE next cycle; core_reset=1, busy=0, overflow=0, words_loaded=0.
  - A subsequent start with a full 1-word stream writes addr 0 correctly.
- In DONE pulse start, then send 01 00 EF BE AD DE:
  - core_reset=1 the cycle after start.
  - Single write: addr 0 data 0xDEADBEEF.
  - done=1 again.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core/instruction-memory types and sizes.
// Used by the loader, the core and the memory wrappers.
package core_pkg;
  localparam int IMEM_ADDR_WIDTH = 7;
  localparam int INSTR_WIDTH     = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE
  } loader_state_t;
endpackage

// File: rtl/word_assembler.sv
// Packs four bytes LSB-first into a 32-bit word; word_full strobes on the 4th byte.
// Zero latency: word already includes the byte presented with byte_en; no backpressure.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);
  logic [1:0]  byte_cnt;
  logic [31:0] word_buf;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt <= 2'd0;
      word_buf <= 32'd0;
    end else if (byte_en) begin
      word_buf[{byte_cnt, 3'b000} +: 8] <= byte_in;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Merge the in-flight byte so the caller can capture the whole word on word_full.
  always_comb begin
    word = word_buf;
    if (byte_en) word[{byte_cnt, 3'b000} +: 8] = byte_in;
  end

  assign word_full = byte_en && (byte_cnt == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream (count header + LE words) into instruction memory, core held in reset.
// mem_wren one cycle after the 4th byte of each word; in_valid low stalls indefinitely.
module imem_loader
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = INSTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [15:0]           words_loaded
);
  localparam logic [16:0] DEPTH = 17'(1 << ADDR_WIDTH);

  loader_state_t state, next_state;
  logic [7:0]    n_lo;
  logic [15:0]   n_words;
  logic [15:0]   n_full;
  logic [15:0]   words_inc;
  logic          hs;
  logic          load_start;
  logic [31:0]   asm_word;
  logic          word_full;

  assign hs         = in_valid && in_ready;
  assign load_start = start && (state == IDLE || state == DONE);
  assign n_full     = {in_data, n_lo};
  assign words_inc  = words_loaded + 16'd1;

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (load_start),
    .byte_en   (hs && state == DATA),
    .byte_in   (in_data),
    .word      (asm_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = HDR0;
      HDR0:    if (hs) next_state = HDR1;
      HDR1:    if (hs) next_state = (n_full == 16'd0) ? DONE : DATA;
      DATA:    if (word_full) next_state = WRITE;
      WRITE:   next_state = (words_inc == n_words) ? DONE : DATA;
      DONE:    if (start) next_state = HDR0;
      default: next_state = IDLE;
    endcase
  end

  assign in_ready   = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign busy       = in_ready || (state == WRITE);
  assign done       = (state == DONE);
  assign core_reset = reset || (state != DONE);

  // Write port is registered at the last byte so addr/data stay put between words.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_lo         <= 8'd0;
      n_words      <= 16'd0;
      words_loaded <= 16'd0;
      overflow     <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_wren     <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      if (load_start) begin
        words_loaded <= 16'd0;
        overflow     <= 1'b0;
      end
      if (state == HDR0 && hs) n_lo <= in_data;
      if (state == HDR1 && hs) begin
        n_words <= n_full;
        if ({1'b0, n_full} > DEPTH) overflow <= 1'b1;
      end
      if (word_full) begin
        mem_data <= DATA_WIDTH'(asm_word);
        mem_addr <= words_loaded[ADDR_WIDTH-1:0];
        mem_wren <= ({1'b0, words_loaded} < DEPTH);
      end
      if (state == WRITE) words_loaded <= words_inc;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level model of expected memory writes.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_wren, core_reset, busy, done, overflow;
  logic [6:0]  mem_addr;
  logic [31:0] mem_data;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .core_reset(core_reset), .busy(busy), .done(done), .overflow(overflow),
    .words_loaded(words_loaded)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  // Every observed write must match the model's next expected write.
  always @(negedge clk) begin
    if (mem_wren) begin
      check_val("in_ready_in_write", {31'd0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", {25'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_val("wr_addr", {25'd0, mem_addr}, {25'd0, e.addr});
        check_val("wr_data", mem_data, e.data);
      end
    end
  end

  // Model: header is N little-endian, then N words LE; only the first 128 land in memory.
  task automatic build_stream(input int n, input logic [7:0] payload[$],
                              output logic [7:0] s[$]);
    logic [15:0] nv;
    nv = 16'(n);
    s = {};
    s.push_back(nv[7:0]);
    s.push_back(nv[15:8]);
    foreach (payload[i]) s.push_back(payload[i]);
    for (int w = 0; w < n; w++) begin
      wr_t e;
      e.addr = 7'(w % 128);
      e.data = {payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]};
      if (w < 128) exp_q.push_back(e);
    end
  endtask

  // mode 0: valid always high; 1: valid every other cycle; 2: random gaps.
  task automatic send_bytes(input logic [7:0] s[$], input int mode);
    int idx = 0;
    int cyc = 0;
    logic v;
    while (idx < s.size() && cyc < 20000) begin
      @(negedge clk);
      #1;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data  = v ? s[idx] : 8'($urandom);
      if (v && in_ready) idx++;
      cyc++;
    end
    if (idx < s.size()) check_val("send_timeout", idx, s.size());
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    @(negedge clk);
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_load(input string tag, input int n, input logic [7:0] payload[$],
                          input int mode);
    logic [7:0] s[$];
    build_stream(n, payload, s);
    pulse_start();
    send_bytes(s, mode);
    wait_done(tag);
    check_val({tag, "_core_reset"}, {31'd0, core_reset}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_words"}, {16'd0, words_loaded}, 32'(n));
    check_val({tag, "_overflow"}, {31'd0, overflow}, (n > 128) ? 32'd1 : 32'd0);
    check_val({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] pay[$];
    logic [7:0] s[$];

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
    check_val("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
    check_val("rst_mem_data", mem_data, 32'd0);
    check_val("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_overflow", {31'd0, overflow}, 32'd0);
    check_val("rst_words", {16'd0, words_loaded}, 32'd0);

    pay = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'hB3, 8'h85, 8'hA5, 8'h00};
    run_load("two_words", 2, pay, 0);

    pay = {};
    run_load("empty", 0, pay, 0);

    pay = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'hB3, 8'h85, 8'hA5, 8'h00};
    run_load("toggle", 2, pay, 1);

    pay = {};
    for (int i = 0; i < 5; i++) pay.push_back(8'($urandom));
    pay = {};
    for (int i = 0; i < 12; i++) pay.push_back(8'($urandom));
    run_load("random3", 3, pay, 2);

    // 129-word load: overflow must appear right after the header.
    pay = {};
    for (int i = 0; i < 516; i++) pay.push_back(8'($urandom));
    build_stream(129, pay, s);
    pulse_start();
    send_bytes(s[0:1], 0);
    @(negedge clk);
    check_val("ovf_after_hdr", {31'd0, overflow}, 32'd1);
    send_bytes(s[2:$], 2);
    wait_done("ovf");
    check_val("ovf_words", {16'd0, words_loaded}, 32'd129);
    check_val("ovf_sticky", {31'd0, overflow}, 32'd1);
    check_val("ovf_pending", exp_q.size(), 32'd0);

    // Reset after 6 payload bytes of a 2-word load: only word 0 reaches memory.
    pay = {};
    for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
    build_stream(2, pay, s);
    void'(exp_q.pop_back());
    pulse_start();
    send_bytes(s[0:7], 2);
    @(negedge clk);
    check_val("mid_words_before", {16'd0, words_loaded}, 32'd1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("mid_core_reset", {31'd0, core_reset}, 32'd1);
    check_val("mid_busy", {31'd0, busy}, 32'd0);
    check_val("mid_overflow", {31'd0, overflow}, 32'd0);
    check_val("mid_words", {16'd0, words_loaded}, 32'd0);
    check_val("mid_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("mid_pending", exp_q.size(), 32'd0);
    pay = {};
    for (int i = 0; i < 4; i++) pay.push_back(8'($urandom));
    run_load("after_rst", 1, pay, 0);

    // Restart from DONE: core goes back into reset the cycle after start.
    pay = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    build_stream(1, pay, s);
    pulse_start();
    @(negedge clk);
    check_val("restart_core_reset", {31'd0, core_reset}, 32'd1);
    check_val("restart_done", {31'd0, done}, 32'd0);
    send_bytes(s, 0);
    wait_done("restart");
    check_val("restart_core_rel", {31'd0, core_reset}, 32'd0);
    check_val("restart_words", {16'd0, words_loaded}, 32'd1);
    check_val("restart_pending", exp_q.size(), 32'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
